// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: access-size encodings, FSM states and
// the byte-lane mapping used by both stores and loads.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  // Byte enables for an access of the given size at the given low address bits.
  function automatic logic [BE_W-1:0] calc_byte_en(input size_e size,
                                                    input logic [1:0] addr_lo);
    logic [BE_W-1:0] be;
    be = '0;
    case (size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'(4'b0001 << addr_lo);
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_controller_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_stage_controller_if;
  import mem_stage_pkg::*;

  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [BE_W-1:0]   MemByteEn;
  logic [DATA_W-1:0] MemWData;
  logic              MemAck;
  logic [DATA_W-1:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemByteEn, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemByteEn, MemWData,
    output MemAck, MemRData
  );

endinterface

// File: rtl/mem_align_unit.sv
// mem_align_unit: combinational store lane steering and load lane
// extraction with sign extension.
module mem_align_unit
  import mem_stage_pkg::*;
(
  input  size_e             i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [BE_W-1:0]   o_byte_en,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Store side: lane enables and replicated write data.
  always_comb begin
    o_byte_en = calc_byte_en(i_size, i_addr_lo);
    o_wdata   = i_wdata;
    case (i_size)
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  // Load side: pick the addressed lane and sign-extend sub-word results.
  always_comb begin
    w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_byte  = i_rdata[7:0];
    o_rdata = '0;
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    case (i_size)
      SZ_WORD: o_rdata = i_rdata;
      SZ_HALF: o_rdata = {{16{w_half[15]}}, w_half};
      SZ_BYTE: o_rdata = {{24{w_byte[7]}}, w_byte};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: MEM pipeline stage. Runs the req/ack handshake to
// data memory, stalls the front end while an access is outstanding,
// resolves branches and owns the MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned word/half accesses instead of
// silently ignoring the offending low address bits.
module mem_stage_controller
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RegWriteIn,
  input  logic                  BranchIn,
  input  logic                  MemToRegIn,
  input  logic                  JalIn,
  input  logic                  ZeroIn,
  input  logic [1:0]            MemWriteIn,
  input  logic [1:0]            MemReadIn,
  input  logic [DATA_W-1:0]     RData2In,
  input  logic [DATA_W-1:0]     ALUResultIn,
  input  logic [DATA_W-1:0]     PCAddResultIn,
  input  logic [DATA_W-1:0]     BranchPCIn,
  input  logic [REG_W-1:0]      RdRegIn,
  mem_stage_controller_if.master bus,
  output logic                  Stall,
  output logic                  PCSrc,
  output logic [DATA_W-1:0]     BranchTarget,
  output logic                  RegWriteOut,
  output logic                  MemToRegOut,
  output logic                  JalOut,
  output logic [DATA_W-1:0]     ReadDataOut,
  output logic [DATA_W-1:0]     ALUResultOut,
  output logic [DATA_W-1:0]     PCAddResultOut,
  output logic [REG_W-1:0]      RdRegOut,
  output logic                  BusErrOut,
  output logic                  MisalignOut
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_buserr;
  size_e                 w_size;
  logic                  w_is_load;
  logic                  w_misalign;
  logic                  w_mem_op;
  logic                  w_timeout;
  logic [DATA_W-1:0]     w_load_data;

  // A read wins over a write when both size fields are nonzero.
  assign w_is_load = (MemReadIn != 2'b00);
  assign w_size    = w_is_load ? size_e'(MemReadIn) : size_e'(MemWriteIn);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == SZ_WORD) && (ALUResultIn[1:0] != 2'b00)) ||
                      ((w_size == SZ_HALF) && ALUResultIn[0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_mem_op  = (w_size != SZ_NONE) && !w_misalign;
  assign w_timeout = (r_state == ACCESS) && !bus.MemAck &&
                     (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  assign bus.MemAddr = {ALUResultIn[DATA_W-1:2], 2'b00};
  assign BranchTarget = BranchPCIn;

  mem_align_unit u_align (
    .i_size    (w_size),
    .i_addr_lo (ALUResultIn[1:0]),
    .i_wdata   (RData2In),
    .i_rdata   (bus.MemRData),
    .o_byte_en (bus.MemByteEn),
    .o_wdata   (bus.MemWData),
    .o_rdata   (w_load_data)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic; an ack in the timeout cycle still counts as success.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_mem_op) w_state_nxt = ACCESS;
      ACCESS:  if (bus.MemAck || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stall, bus request/direction, branch taken.
  always_comb begin
    Stall      = 1'b0;
    bus.MemReq = 1'b0;
    bus.MemWe  = 1'b0;
    PCSrc      = 1'b0;
    case (r_state)
      IDLE: begin
        Stall = w_mem_op;
        PCSrc = BranchIn & ZeroIn;
      end
      ACCESS: begin
        Stall      = 1'b1;
        bus.MemReq = 1'b1;
        bus.MemWe  = (MemWriteIn != 2'b00) && !w_is_load;
      end
      default: ;
    endcase
  end

  // Timeout counter plus captured load data / bus-error result of the access.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_buserr <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
      if (bus.MemAck) begin
        r_rdata  <= w_load_data;
        r_buserr <= 1'b0;
      end else if (w_timeout) begin
        r_rdata  <= '0;
        r_buserr <= 1'b1;
      end
    end else begin
      r_cnt <= '0;
      if (r_state == IDLE) begin
        r_rdata  <= '0;
        r_buserr <= 1'b0;
      end
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RegWriteOut    <= 1'b0;
      MemToRegOut    <= 1'b0;
      JalOut         <= 1'b0;
      ReadDataOut    <= '0;
      ALUResultOut   <= '0;
      PCAddResultOut <= '0;
      RdRegOut       <= '0;
      BusErrOut      <= 1'b0;
      MisalignOut    <= 1'b0;
    end else if (Stall) begin
      RegWriteOut <= 1'b0;
      BusErrOut   <= 1'b0;
      MisalignOut <= 1'b0;
    end else begin
      RegWriteOut    <= RegWriteIn && !w_misalign && !((r_state == DONE) && r_buserr);
      MemToRegOut    <= MemToRegIn;
      JalOut         <= JalIn;
      ReadDataOut    <= ((r_state == DONE) && w_is_load) ? r_rdata : '0;
      ALUResultOut   <= ALUResultIn;
      PCAddResultOut <= PCAddResultIn;
      RdRegOut       <= RdRegIn;
      BusErrOut      <= (r_state == DONE) && r_buserr;
      MisalignOut    <= w_misalign;
    end
  end

endmodule
